// File: rtl/mul_rr_sched_if.sv
// Bundle between the round-robin multiplier scheduler, its requesters,
// the shared pipelined multiplier and the response consumer.
interface mul_rr_sched_if #(
    parameter int DATA_WIDTH = 7,
    parameter int NREQ       = 4,
    parameter int LATENCY    = 2
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(LATENCY + 1);

    logic                       hold;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ*DATA_WIDTH-1:0] req_a;
    logic [NREQ*DATA_WIDTH-1:0] req_b;
    logic [NREQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]      mul_a;
    logic [DATA_WIDTH-1:0]      mul_b;
    logic [2*DATA_WIDTH-1:0]    mul_q;
    logic                       rsp_valid;
    logic [IDW-1:0]             rsp_id;
    logic [2*DATA_WIDTH-1:0]    rsp_data;
    logic [CW-1:0]              inflight;

    // Scheduler side
    modport slave (
        input  hold, req_valid, req_a, req_b, mul_q,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, inflight
    );

    // Environment side: requesters, multiplier and response sink
    modport master (
        output hold, req_valid, req_a, req_b, mul_q,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, inflight
    );
endinterface

// File: rtl/mul_rr_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ
// requesters. One operand pair is granted per cycle; a tag pipe matching
// the multiplier latency labels each returning product with its requester.
module mul_rr_sched #(
    parameter int DATA_WIDTH = 7,
    parameter int NREQ       = 4,
    parameter int LATENCY    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_rr_sched_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(LATENCY + 1);

    logic [IDW-1:0]              last_q, last_d;
    logic [LATENCY-1:0]          v_q, v_d;
    logic [LATENCY-1:0][IDW-1:0] id_q, id_d;

    logic           found;
    logic           grant;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] cand;

    // Search requesters starting just after the last one served
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(last_q) + k) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
    end

    assign grant = found && !bus.hold;

    // One-hot ready and operand mux toward the multiplier
    always_comb begin
        bus.req_ready = '0;
        bus.mul_a     = '0;
        bus.mul_b     = '0;
        if (grant) begin
            bus.req_ready[gnt_id] = 1'b1;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (IDW'(i) == gnt_id) begin
                    bus.mul_a = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
                    bus.mul_b = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Next state: pointer advances on transfer, tag pipe shifts every edge
    always_comb begin
        last_d   = grant ? gnt_id : last_q;
        v_d      = '0;
        id_d     = '0;
        v_d[0]   = grant;
        id_d[0]  = gnt_id;
        for (int unsigned k = 1; k < LATENCY; k++) begin
            v_d[k]  = v_q[k-1];
            id_d[k] = id_q[k-1];
        end
    end

    // State registers; reset drops every tag so pending products are never reported
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDW'(NREQ - 1);
            v_q    <= '0;
            id_q   <= '0;
        end else begin
            last_q <= last_d;
            v_q    <= v_d;
            id_q   <= id_d;
        end
    end

    // Response outputs and in-flight count from the tag pipe
    always_comb begin
        bus.rsp_valid = v_q[LATENCY-1];
        bus.rsp_id    = id_q[LATENCY-1];
        bus.rsp_data  = v_q[LATENCY-1] ? bus.mul_q : '0;
        bus.inflight  = '0;
        for (int unsigned k = 0; k < LATENCY; k++) begin
            bus.inflight = bus.inflight + CW'(v_q[k]);
        end
    end
endmodule

// File: tb/tb_mul_rr_sched.sv
// Bench for mul_rr_sched: directed scenarios plus randomized traffic,
// checked against a transaction-level model (priority search + response queue).
module tb_mul_rr_sched;
    localparam int DW   = 7;
    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic clk;
    logic rst_n;

    mul_rr_sched_if #(.DATA_WIDTH(DW), .NREQ(NREQ), .LATENCY(LAT)) bus ();

    mul_rr_sched #(.DATA_WIDTH(DW), .NREQ(NREQ), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared pipelined multiplier: product appears LAT edges after operands
    logic [2*DW-1:0] m_pipe [LAT];
    always @(posedge clk) begin
        m_pipe[0] <= (2*DW)'(bus.mul_a) * (2*DW)'(bus.mul_b);
        for (int k = 1; k < LAT; k++) m_pipe[k] <= m_pipe[k-1];
    end
    assign bus.mul_q = m_pipe[LAT-1];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester state (operands held stable while pending)
    logic          pend [NREQ];
    logic [DW-1:0] opa  [NREQ];
    logic [DW-1:0] opb  [NREQ];
    logic          hold_r;

    // Reference model
    typedef struct { int t; int id; int p; } txn_t;
    txn_t q[$];
    int   m_last;
    int   cyc;

    // Observed values from the most recent step
    int dut_grant, dut_v, dut_id, dut_d;

    task automatic clear_pend();
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; opa[i] = '0; opb[i] = '0;
        end
        hold_r = 1'b0;
    endtask

    task automatic step();
        int g;
        int exp_infl;
        int exp_v, exp_id, exp_d;
        @(negedge clk);
        bus.hold = hold_r;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]         = pend[i];
            bus.req_a[i*DW +: DW]    = opa[i];
            bus.req_b[i*DW +: DW]    = opb[i];
        end
        #1;
        g = -1;
        if (!hold_r)
            for (int k = 1; k <= NREQ; k++)
                if (g < 0 && pend[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;

        dut_grant = -1;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) dut_grant = i;
        dut_v  = int'(bus.rsp_valid);
        dut_id = int'(bus.rsp_id);
        dut_d  = int'(bus.rsp_data);

        check("req_ready", int'(bus.req_ready), (g >= 0) ? (1 << g) : 0);
        check("mul_a", int'(bus.mul_a), (g >= 0) ? int'(opa[g]) : 0);
        check("mul_b", int'(bus.mul_b), (g >= 0) ? int'(opb[g]) : 0);

        exp_infl = q.size();
        exp_v = 0; exp_id = 0; exp_d = 0;
        if (q.size() > 0 && q[0].t + LAT == cyc) begin
            exp_v = 1; exp_id = q[0].id; exp_d = q[0].p;
            void'(q.pop_front());
        end
        check("inflight", int'(bus.inflight), exp_infl);
        check("rsp_valid", dut_v, exp_v);
        check("rsp_data", dut_d, exp_d);
        if (exp_v == 1) check("rsp_id", dut_id, exp_id);

        if (g >= 0) begin
            q.push_back('{t: cyc, id: g, p: int'(opa[g]) * int'(opb[g])});
            m_last  = g;
            pend[g] = 1'b0;
        end
        cyc++;
    endtask

    // Asynchronous reset mid-cycle, released just after a rising edge
    task automatic do_reset();
        bus.req_valid = '0;
        bus.hold      = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("rst_inflight", int'(bus.inflight), 0);
        check("rst_rsp_id", int'(bus.rsp_id), 0);
        q.delete();
        m_last = NREQ - 1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic all_valid(input int bval);
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b1; opa[i] = DW'(i + 1); opb[i] = DW'(bval);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.hold      = 1'b0;
        rst_n         = 1'b0;
        cyc           = 0;
        m_last        = NREQ - 1;
        clear_pend();
        #2;
        do_reset();

        // Single request
        pend[0] = 1'b1; opa[0] = 7'd5; opb[0] = 7'd9;
        step();
        check("single_grant", dut_grant, 0);
        step();
        step();
        check("single_v", dut_v, 1);
        check("single_id", dut_id, 0);
        check("single_data", dut_d, 45);

        // Round robin with all requesters valid
        do_reset();
        for (int c = 0; c < 8; c++) begin
            all_valid(10);
            step();
            check("rr_order", dut_grant, c % NREQ);
            if (c >= LAT) check("rr_prod", dut_d, ((c - LAT) % NREQ + 1) * 10);
        end
        clear_pend();
        step();
        step();

        // Hold after grant to requester 1
        do_reset();
        all_valid(3); step(); check("hold_g0", dut_grant, 0);
        all_valid(3); step(); check("hold_g1", dut_grant, 1);
        hold_r = 1'b1;
        for (int h = 0; h < 3; h++) begin
            all_valid(3);
            step();
            check("hold_ready", dut_grant, -1);
            check("hold_rsp", dut_v, (h < 2) ? 1 : 0);
        end
        hold_r = 1'b0;
        all_valid(3); step(); check("hold_next", dut_grant, 2);
        clear_pend();
        step();
        step();

        // Maximum and zero operands on requester 3
        pend[3] = 1'b1; opa[3] = 7'd127; opb[3] = 7'd127;
        step();
        check("max_grant", dut_grant, 3);
        step();
        step();
        check("max_data", dut_d, 16129);
        check("max_id", dut_id, 3);
        pend[3] = 1'b1; opa[3] = 7'd0; opb[3] = 7'd127;
        step(); step(); step();
        check("zero_v", dut_v, 1);
        check("zero_data", dut_d, 0);

        // Sparse requests wrapping around the pointer
        do_reset();
        pend[2] = 1'b1; opa[2] = 7'd3; opb[2] = 7'd4;
        step(); check("sparse_g2", dut_grant, 2);
        step();
        pend[1] = 1'b1; opa[1] = 7'd6; opb[1] = 7'd7;
        step(); check("sparse_g1", dut_grant, 1);
        check("sparse_r2_id", dut_id, 2);
        check("sparse_r2_v", dut_v, 1);
        step();
        step(); check("sparse_r1_id", dut_id, 1);
        check("sparse_r1_d", dut_d, 42);

        // Reset mid-stream, then first grant goes to requester 0
        all_valid(5); step();
        all_valid(5); step();
        all_valid(5); step();
        do_reset();
        all_valid(5); step();
        check("rst_first_grant", dut_grant, 0);
        clear_pend();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    opa[i]  = DW'($urandom);
                    opb[i]  = DW'($urandom);
                end
            end
            hold_r = ($urandom % 5 == 0);
            step();
            if (c % 500 == 499) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
